// File: rtl/ds2_pkg.sv
// Shared types and constants for the DualShock 2 host interface.
package ds2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ATT_LO,
    CLK_LO,
    CLK_HI,
    GAP,
    ATT_HI
  } ds2_state_e;

  // Which command frame is being sent. ENTER/SETMODE/EXIT run back to back.
  typedef enum logic [1:0] {
    TXN_POLL,
    TXN_ENTER,
    TXN_SETMODE,
    TXN_EXIT
  } ds2_txn_e;

  localparam logic [7:0] CMD_START   = 8'h01;
  localparam logic [7:0] CMD_POLL    = 8'h42;
  localparam logic [7:0] CMD_CONFIG  = 8'h43;
  localparam logic [7:0] CMD_SETMODE = 8'h44;
  localparam logic [7:0] CMD_PAD     = 8'h5A;

  localparam logic [7:0] ID_DIGITAL  = 8'h41;
  localparam logic [7:0] ID_ANALOG   = 8'h73;
  localparam logic [7:0] ID_DS2      = 8'h79;
  localparam logic [7:0] ID_NONE     = 8'hFF;

  // Bit positions inside response byte 3 (after inversion).
  localparam int B3_SELECT = 0;
  localparam int B3_LSTICK = 1;
  localparam int B3_RSTICK = 2;
  localparam int B3_START  = 3;
  localparam int B3_UP     = 4;
  localparam int B3_RIGHT  = 5;
  localparam int B3_DOWN   = 6;
  localparam int B3_LEFT   = 7;

  // Bit positions inside response byte 4 (after inversion).
  localparam int B4_L2       = 0;
  localparam int B4_R2       = 1;
  localparam int B4_L1       = 2;
  localparam int B4_R1       = 3;
  localparam int B4_TRIANGLE = 4;
  localparam int B4_CIRCLE   = 5;
  localparam int B4_CROSS    = 6;
  localparam int B4_SQUARE   = 7;

  // Number of bytes in a frame.
  function automatic logic [3:0] txn_len(ds2_txn_e t);
    return (t == TXN_ENTER) ? 4'd5 : 4'd9;
  endfunction

  // Command byte number idx of frame t; mm selects analog (1) / digital (0).
  function automatic logic [7:0] cmd_byte(ds2_txn_e t, logic [3:0] idx, logic mm);
    logic [7:0] b;
    b = 8'h00;
    if (idx == 4'd0) begin
      b = CMD_START;
    end else begin
      case (t)
        TXN_POLL:    if (idx == 4'd1) b = CMD_POLL;
        TXN_ENTER:   if (idx == 4'd1) b = CMD_CONFIG; else if (idx == 4'd3) b = 8'h01;
        TXN_SETMODE: if (idx == 4'd1) b = CMD_SETMODE;
                     else if (idx == 4'd3) b = {7'd0, mm};
                     else if (idx == 4'd4) b = 8'h03;
        TXN_EXIT:    if (idx == 4'd1) b = CMD_CONFIG; else if (idx >= 4'd4) b = CMD_PAD;
        default:     b = 8'h00;
      endcase
    end
    return b;
  endfunction

endpackage

// File: rtl/ds2_byte_xfer.sv
// Full-duplex 8-bit LSB-first shifter. Generates the pad clock:
// CMD changes on each falling edge, DAT is captured on each rising edge.
// Handshake: i_start (one cycle, only honoured when idle) loads i_tx_byte;
// o_done pulses one cycle after the last high half-period, with o_rx_byte valid.
module ds2_byte_xfer #(
  parameter int CLK_HALF = 54
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  logic [7:0] i_tx_byte,
  input  logic       i_dat,
  output logic       o_done,
  output logic [7:0] o_rx_byte,
  output logic       o_cmd,
  output logic       o_sclk
);

  localparam int CW = $clog2(CLK_HALF + 1);

  logic          r_busy;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_tx;
  logic [7:0]    r_rx;
  logic          r_done;
  logic          r_cmd;
  logic          r_sclk;

  // Half-period timer driving the clock phases and the two shift registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_bit  <= 3'd0;
      r_tx   <= 8'h00;
      r_rx   <= 8'h00;
      r_done <= 1'b0;
      r_cmd  <= 1'b1;
      r_sclk <= 1'b1;
    end else begin
      r_done <= 1'b0;
      if (!r_busy) begin
        if (i_start) begin
          r_busy <= 1'b1;
          r_tx   <= i_tx_byte;
          r_cmd  <= i_tx_byte[0];
          r_sclk <= 1'b0;
          r_cnt  <= '0;
          r_bit  <= 3'd0;
        end
      end else if (r_cnt == CW'(CLK_HALF - 1)) begin
        r_cnt <= '0;
        if (!r_sclk) begin
          r_sclk <= 1'b1;
          r_rx   <= {i_dat, r_rx[7:1]};
        end else if (r_bit == 3'd7) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
          r_cmd  <= 1'b1;
        end else begin
          r_sclk <= 1'b0;
          r_bit  <= r_bit + 3'd1;
          r_tx   <= {1'b0, r_tx[7:1]};
          r_cmd  <= r_tx[1];
        end
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_done    = r_done;
  assign o_rx_byte = r_rx;
  assign o_cmd     = r_cmd;
  assign o_sclk    = r_sclk;

endmodule

// File: rtl/dualshock2.sv
// DualShock 2 host: polls once per vsync, switches digital/analog mode
// with the ENTER/SETMODE/EXIT sequence, and decodes buttons and sticks.
module dualshock2
  import ds2_pkg::*;
#(
  parameter int CLK_HALF  = 54,
  parameter int ATT_SETUP = 108,
  parameter int BYTE_GAP  = 216
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vsync,
  input  logic       ds2_dat,
  input  logic       ds2_ack,
  input  logic       analog,
  output logic       ds2_cmd,
  output logic       ds2_att,
  output logic       ds2_clk,
  output logic [7:0] stick_lx,
  output logic [7:0] stick_ly,
  output logic [7:0] stick_rx,
  output logic [7:0] stick_ry,
  output logic       key_up,
  output logic       key_down,
  output logic       key_left,
  output logic       key_right,
  output logic       key_l1,
  output logic       key_l2,
  output logic       key_r1,
  output logic       key_r2,
  output logic       key_triangle,
  output logic       key_square,
  output logic       key_circle,
  output logic       key_cross,
  output logic       key_start,
  output logic       key_select,
  output logic       key_lstick,
  output logic       key_rstick,
  output logic [7:0] debug1,
  output logic [7:0] debug2
);

  ds2_state_e  r_state, w_nxt;
  ds2_txn_e    r_txn;
  logic [15:0] r_cnt;
  logic [3:0]  r_byte;
  logic        r_mm, r_mode, r_att;
  logic [7:0]  r_rx [0:8];
  logic [7:0]  r_k3, r_k4, r_lx, r_ly, r_rx_s, r_ry, r_debug1, r_debug2;
  logic        r_vs_s1, r_vs_s2, r_vs_s3, r_dat_s1, r_dat_s2, r_an_s1, r_an_s2;
  logic        w_go, w_start, w_att_rise, w_xdone, w_xclk, w_xcmd, w_vs_rise;
  logic [7:0]  w_rx_byte, w_tx_byte;
  logic [3:0]  w_last;
  logic        w_unused_ack;

  assign w_unused_ack = ds2_ack;
  assign w_vs_rise    = r_vs_s2 & ~r_vs_s3;
  assign w_last       = txn_len(r_txn) - 4'd1;
  assign w_tx_byte    = cmd_byte(r_txn, r_byte, r_mm);

  // Two-flop synchronisers for the asynchronous inputs, plus a vsync edge tap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      {r_vs_s1, r_vs_s2, r_vs_s3} <= 3'b000;
      {r_dat_s1, r_dat_s2}        <= 2'b11;
      {r_an_s1, r_an_s2}          <= 2'b00;
    end else begin
      {r_vs_s1, r_vs_s2, r_vs_s3} <= {vsync, r_vs_s1, r_vs_s2};
      {r_dat_s1, r_dat_s2}        <= {ds2_dat, r_dat_s1};
      {r_an_s1, r_an_s2}          <= {analog, r_an_s1};
    end
  end

  ds2_byte_xfer #(.CLK_HALF(CLK_HALF)) u_xfer (
    .clk       (clk),
    .rst       (rst),
    .i_start   (w_start),
    .i_tx_byte (w_tx_byte),
    .i_dat     (r_dat_s2),
    .o_done    (w_xdone),
    .o_rx_byte (w_rx_byte),
    .o_cmd     (w_xcmd),
    .o_sclk    (w_xclk)
  );

  // State register and phase timer; the timer restarts on every state change.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= 16'd0;
    end else begin
      r_state <= w_nxt;
      r_cnt   <= (w_nxt != r_state) ? 16'd0 : r_cnt + 16'd1;
    end
  end

  // Next-state logic. CLK_LO/CLK_HI follow the shifter's clock phase; GAP
  // doubles as the ATT-high pause between CONFIG frames when r_att is set.
  always_comb begin
    w_nxt      = r_state;
    w_go       = 1'b0;
    w_start    = 1'b0;
    w_att_rise = 1'b0;
    case (r_state)
      IDLE:   if (w_vs_rise) begin w_nxt = ATT_LO; w_go = 1'b1; end
      ATT_LO: if (r_cnt == 16'(ATT_SETUP - 1)) begin w_nxt = CLK_LO; w_start = 1'b1; end
      CLK_LO: if (w_xclk) w_nxt = CLK_HI;
      CLK_HI: begin
        if (w_xdone)      w_nxt = (r_byte == w_last) ? ATT_HI : GAP;
        else if (!w_xclk) w_nxt = CLK_LO;
      end
      GAP: begin
        if (r_cnt == 16'(BYTE_GAP - 1)) begin
          if (r_att) begin
            w_nxt = ATT_LO;
          end else begin
            w_nxt   = CLK_LO;
            w_start = 1'b1;
          end
        end
      end
      ATT_HI: begin
        if (r_cnt == 16'(ATT_SETUP - 1)) begin
          w_att_rise = 1'b1;
          w_nxt = (r_txn == TXN_ENTER || r_txn == TXN_SETMODE) ? GAP : IDLE;
        end
      end
      default: w_nxt = IDLE;
    endcase
  end

  // Frame sequencing, response capture, mode tracking and end-of-frame decode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_txn    <= TXN_POLL;
      r_byte   <= 4'd0;
      r_mm     <= 1'b0;
      r_mode   <= 1'b0;
      r_att    <= 1'b1;
      for (int i = 0; i < 9; i++) r_rx[i] <= 8'h00;
      r_k3     <= 8'h00;
      r_k4     <= 8'h00;
      r_lx     <= 8'h80;
      r_ly     <= 8'h80;
      r_rx_s   <= 8'h80;
      r_ry     <= 8'h80;
      r_debug1 <= 8'h00;
      r_debug2 <= 8'h00;
    end else begin
      if (w_go) begin
        r_txn <= (r_an_s2 == r_mode) ? TXN_POLL : TXN_ENTER;
        r_mm  <= r_an_s2;
      end
      if (w_nxt == ATT_LO && r_state != ATT_LO) begin
        r_att  <= 1'b0;
        r_byte <= 4'd0;
      end
      if (w_xdone) begin
        if (r_byte <= 4'd8) r_rx[r_byte] <= w_rx_byte;
        r_byte <= r_byte + 4'd1;
      end
      if (w_att_rise) begin
        r_att    <= 1'b1;
        r_debug1 <= r_rx[1];
        r_debug2 <= r_debug2 + 8'd1;
        case (r_txn)
          TXN_ENTER:   r_txn  <= TXN_SETMODE;
          TXN_SETMODE: r_txn  <= TXN_EXIT;
          TXN_EXIT:    r_mode <= r_mm;
          default: begin
            if (r_rx[1] == ID_NONE) begin
              r_k3 <= 8'h00;
              r_k4 <= 8'h00;
            end else begin
              r_k3 <= ~r_rx[3];
              r_k4 <= ~r_rx[4];
              if (r_rx[1] == ID_ANALOG || r_rx[1] == ID_DS2) begin
                r_rx_s <= r_rx[5];
                r_ry   <= r_rx[6];
                r_lx   <= r_rx[7];
                r_ly   <= r_rx[8];
              end else begin
                {r_rx_s, r_ry, r_lx, r_ly} <= 32'h80808080;
              end
            end
          end
        endcase
      end
    end
  end

  assign ds2_att      = r_att;
  assign ds2_clk      = w_xclk;
  assign ds2_cmd      = w_xcmd;
  assign stick_lx     = r_lx;
  assign stick_ly     = r_ly;
  assign stick_rx     = r_rx_s;
  assign stick_ry     = r_ry;
  assign debug1       = r_debug1;
  assign debug2       = r_debug2;
  assign key_select   = r_k3[B3_SELECT];
  assign key_lstick   = r_k3[B3_LSTICK];
  assign key_rstick   = r_k3[B3_RSTICK];
  assign key_start    = r_k3[B3_START];
  assign key_up       = r_k3[B3_UP];
  assign key_right    = r_k3[B3_RIGHT];
  assign key_down     = r_k3[B3_DOWN];
  assign key_left     = r_k3[B3_LEFT];
  assign key_l2       = r_k4[B4_L2];
  assign key_r2       = r_k4[B4_R2];
  assign key_l1       = r_k4[B4_L1];
  assign key_r1       = r_k4[B4_R1];
  assign key_triangle = r_k4[B4_TRIANGLE];
  assign key_circle   = r_k4[B4_CIRCLE];
  assign key_cross    = r_k4[B4_CROSS];
  assign key_square   = r_k4[B4_SQUARE];

endmodule

// File: tb/tb_dualshock2.sv
// Bench for dualshock2: a behavioural pad on the serial pins, a frame-level
// model of the host, and one task per scenario.
module tb_dualshock2;

  localparam int CLK_HALF  = 4;
  localparam int ATT_SETUP = 8;
  localparam int BYTE_GAP  = 16;
  localparam int T         = 10;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0, rst = 1'b0, vsync = 1'b0, ds2_ack = 1'b1, analog = 1'b0;
  logic pad_present = 1'b1, pad_bit = 1'b1;
  logic ds2_dat, ds2_cmd, ds2_att, ds2_clk;
  logic [7:0] stick_lx, stick_ly, stick_rx, stick_ry, debug1, debug2;
  logic key_up, key_down, key_left, key_right, key_l1, key_l2, key_r1, key_r2;
  logic key_triangle, key_square, key_circle, key_cross, key_start, key_select, key_lstick, key_rstick;

  always #(T/2) clk = ~clk;
  assign ds2_dat = pad_present ? pad_bit : 1'b1;

  dualshock2 #(.CLK_HALF(CLK_HALF), .ATT_SETUP(ATT_SETUP), .BYTE_GAP(BYTE_GAP)) dut (
    .clk(clk), .rst(rst), .vsync(vsync), .ds2_dat(ds2_dat), .ds2_ack(ds2_ack), .analog(analog),
    .ds2_cmd(ds2_cmd), .ds2_att(ds2_att), .ds2_clk(ds2_clk),
    .stick_lx(stick_lx), .stick_ly(stick_ly), .stick_rx(stick_rx), .stick_ry(stick_ry),
    .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
    .key_l1(key_l1), .key_l2(key_l2), .key_r1(key_r1), .key_r2(key_r2),
    .key_triangle(key_triangle), .key_square(key_square), .key_circle(key_circle), .key_cross(key_cross),
    .key_start(key_start), .key_select(key_select), .key_lstick(key_lstick), .key_rstick(key_rstick),
    .debug1(debug1), .debug2(debug2)
  );

  logic [15:0] keys;
  assign keys = {key_up, key_down, key_left, key_right, key_l1, key_l2, key_r1, key_r2,
                 key_triangle, key_square, key_circle, key_cross, key_start, key_select, key_lstick, key_rstick};
  logic [31:0] sticks;
  assign sticks = {stick_lx, stick_ly, stick_rx, stick_ry};

  int checks = 0, errors = 0;

  // ---------------- pad model / pin monitor ----------------
  logic [7:0] resp [0:8];
  logic [7:0] cap  [0:8];
  int   bitpos = 0;
  bit   mon_en = 1'b0;
  logic [7:0] got_q[$];
  int   len_q[$];
  int   clk_outside = 0, partial = 0, cmd_viol = 0;
  time  t_neg = 0, t_cmd = 0, lo_min = 1000000, lo_max = 0;

  always @(negedge ds2_att) bitpos = 0;
  always @(ds2_cmd) t_cmd = $time;
  // Pad shifts its next response bit out on each falling clock edge.
  always @(negedge ds2_clk) begin
    t_neg = $time;
    if (!ds2_att && bitpos < 72) pad_bit = resp[bitpos/8][bitpos%8];
  end
  // Pad captures CMD on each rising edge; also collect timing figures.
  always @(posedge ds2_clk) begin
    if (mon_en) begin
      if (ds2_att) clk_outside++;
      else begin
        if ($time - t_neg < lo_min) lo_min = $time - t_neg;
        if ($time - t_neg > lo_max) lo_max = $time - t_neg;
        if ($time - t_cmd < CLK_HALF*T) cmd_viol++;
        if (bitpos < 72) cap[bitpos/8][bitpos%8] = ds2_cmd;
        bitpos++;
      end
    end
  end
  // A completed frame is logged when ATT rises.
  always @(posedge ds2_att) begin
    if (mon_en) begin
      if (bitpos % 8 != 0) partial++;
      len_q.push_back(bitpos/8);
      for (int i = 0; i < bitpos/8 && i < 9; i++) got_q.push_back(cap[i]);
    end
  end

  // ---------------- reference model ----------------
  logic [7:0]  exp_q[$];
  int          exp_len_q[$];
  bit          m_mode = 1'b0;
  logic [15:0] m_keys = 16'h0000;
  logic [31:0] m_sticks = 32'h80808080;
  logic [7:0]  m_dbg1 = 8'h00, m_dbg2 = 8'h00;

  function automatic logic [7:0] eff(int i);
    return pad_present ? resp[i] : 8'hFF;
  endfunction

  // Key vector in the same order as 'keys', from raw active-low bytes 3/4.
  function automatic logic [15:0] keys_of(logic [7:0] b3, logic [7:0] b4);
    logic [7:0] p3, p4;
    p3 = ~b3;
    p4 = ~b4;
    return {p3[4], p3[6], p3[7], p3[5], p4[2], p4[0], p4[3], p4[1],
            p4[4], p4[7], p4[5], p4[6], p3[3], p3[0], p3[1], p3[2]};
  endfunction

  function automatic void push_frame(int kind, bit mm);
    logic [7:0] f [0:8];
    int n;
    n = 9;
    case (kind)
      0: f = '{8'h01, 8'h42, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      1: begin f = '{8'h01, 8'h43, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}; n = 5; end
      2: f = '{8'h01, 8'h44, 8'h00, {7'd0, mm}, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00};
      default: f = '{8'h01, 8'h43, 8'h00, 8'h00, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A};
    endcase
    exp_len_q.push_back(n);
    for (int i = 0; i < n; i++) exp_q.push_back(f[i]);
  endfunction

  // Predicts the effect of one vsync; returns the number of frames expected.
  function automatic int model_vsync();
    logic [7:0] id;
    id = eff(1);
    if (analog == m_mode) begin
      push_frame(0, 1'b0);
      m_dbg1 = id;
      m_dbg2 = m_dbg2 + 8'd1;
      if (id == 8'hFF) m_keys = 16'h0000;
      else begin
        m_keys = keys_of(eff(3), eff(4));
        if (id == 8'h73 || id == 8'h79) m_sticks = {eff(7), eff(8), eff(5), eff(6)};
        else m_sticks = 32'h80808080;
      end
      return 1;
    end
    push_frame(1, 1'b0);
    push_frame(2, analog);
    push_frame(3, 1'b0);
    m_dbg1 = id;
    m_dbg2 = m_dbg2 + 8'd3;
    m_mode = analog;
    return 3;
  endfunction

  // Mismatch count between logged and expected frames; empties all queues.
  function automatic int frames_bad();
    int bad;
    bad = 0;
    if (len_q.size() != exp_len_q.size()) bad++;
    else foreach (len_q[i]) if (len_q[i] != exp_len_q[i]) bad++;
    if (got_q.size() != exp_q.size()) bad++;
    else foreach (got_q[i]) if (got_q[i] !== exp_q[i]) bad++;
    len_q.delete(); got_q.delete(); exp_len_q.delete(); exp_q.delete();
    return bad;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic pulse_vsync();
    repeat (4) @(negedge clk);
    vsync = 1'b1;
    repeat (4) @(negedge clk);
    vsync = 1'b0;
  endtask

  // One vsync; optionally a second edge while the DUT is busy. Bounded wait.
  task automatic run_txn(input bit busy_pulse, output bit timed_out);
    int n;
    n = model_vsync();
    pulse_vsync();
    if (busy_pulse) begin
      repeat (40) @(negedge clk);
      vsync = 1'b1;
      repeat (4) @(negedge clk);
      vsync = 1'b0;
    end
    for (int c = 0; c < 3000 && len_q.size() < n; c++) @(negedge clk);
    timed_out = (len_q.size() < n);
    repeat (2*BYTE_GAP + ATT_SETUP) @(negedge clk);
  endtask

  task automatic randomize_resp(input logic [7:0] id);
    resp[0] = 8'hFF;
    resp[1] = id;
    resp[2] = 8'h5A;
    for (int i = 3; i < 9; i++) resp[i] = 8'($urandom_range(0, 255));
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (ds2_att !== 1'b1) begin errors++; $display("FAIL reset_att got %b want 1", ds2_att); end
    checks++; if (ds2_clk !== 1'b1) begin errors++; $display("FAIL reset_clk got %b want 1", ds2_clk); end
    checks++; if (ds2_cmd !== 1'b1) begin errors++; $display("FAIL reset_cmd got %b want 1", ds2_cmd); end
    checks++; if (sticks !== 32'h80808080) begin errors++; $display("FAIL reset_sticks got %h want 80808080", sticks); end
    checks++; if (keys !== 16'h0000) begin errors++; $display("FAIL reset_keys got %h want 0000", keys); end
    checks++; if (debug1 !== 8'h00) begin errors++; $display("FAIL reset_debug1 got %h want 00", debug1); end
    checks++; if (debug2 !== 8'h00) begin errors++; $display("FAIL reset_debug2 got %h want 00", debug2); end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    mon_en = 1'b1;
  endtask

  task automatic test_digital_poll();
    bit to;
    int bad;
    analog = 1'b0;
    resp = '{8'hFF, 8'h41, 8'h5A, 8'hFE, 8'h7F, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    run_txn(1'b0, to);
    checks++; if (to) begin errors++; $display("FAIL dpoll_timeout frames %0d want 1", len_q.size()); end
    bad = frames_bad();
    checks++; if (bad !== 0) begin errors++; $display("FAIL dpoll_frames mismatches %0d want 0", bad); end
    checks++; if (keys !== 16'h0044) begin errors++; $display("FAIL dpoll_keys got %h want 0044", keys); end
    checks++; if (sticks !== 32'h80808080) begin errors++; $display("FAIL dpoll_sticks got %h want 80808080", sticks); end
    checks++; if (debug1 !== 8'h41) begin errors++; $display("FAIL dpoll_debug1 got %h want 41", debug1); end
    checks++; if (debug2 !== 8'h01) begin errors++; $display("FAIL dpoll_debug2 got %h want 01", debug2); end
  endtask

  task automatic test_analog_switch();
    bit to;
    int bad;
    analog = 1'b1;
    randomize_resp(8'h73);
    run_txn(1'b0, to);
    bad = frames_bad();
    checks++; if (to || bad !== 0) begin errors++; $display("FAIL aswitch_frames mismatches %0d timeout %0d want 0 0", bad, to); end
    checks++; if (keys !== m_keys) begin errors++; $display("FAIL aswitch_keys_held got %h want %h", keys, m_keys); end
    checks++; if (debug2 !== m_dbg2) begin errors++; $display("FAIL aswitch_debug2 got %h want %h", debug2, m_dbg2); end
    randomize_resp(8'h73);
    resp[5] = 8'h10; resp[6] = 8'h20; resp[7] = 8'h30; resp[8] = 8'h40;
    run_txn(1'b0, to);
    bad = frames_bad();
    checks++; if (to || bad !== 0) begin errors++; $display("FAIL apoll_frames mismatches %0d timeout %0d want 0 0", bad, to); end
    checks++; if (sticks !== 32'h30401020) begin errors++; $display("FAIL apoll_sticks got %h want 30401020", sticks); end
    checks++; if (keys !== m_keys) begin errors++; $display("FAIL apoll_keys got %h want %h", keys, m_keys); end
    checks++; if (debug1 !== 8'h73) begin errors++; $display("FAIL apoll_debug1 got %h want 73", debug1); end
  endtask

  task automatic test_return_digital();
    bit to;
    int bad;
    analog = 1'b0;
    randomize_resp(8'h41);
    run_txn(1'b0, to);
    bad = frames_bad();
    checks++; if (to || bad !== 0) begin errors++; $display("FAIL rdig_frames mismatches %0d timeout %0d want 0 0", bad, to); end
    run_txn(1'b0, to);
    bad = frames_bad();
    checks++; if (to || bad !== 0) begin errors++; $display("FAIL rdig_poll_frames mismatches %0d timeout %0d want 0 0", bad, to); end
    checks++; if (sticks !== 32'h80808080) begin errors++; $display("FAIL rdig_sticks got %h want 80808080", sticks); end
    checks++; if (keys !== m_keys) begin errors++; $display("FAIL rdig_keys got %h want %h", keys, m_keys); end
  endtask

  task automatic test_random();
    bit to;
    int bad;
    logic [7:0] ids [0:3];
    ids = '{8'h41, 8'h73, 8'h79, 8'h12};
    for (int it = 0; it < 6; it++) begin
      analog = 1'($urandom_range(0, 1));
      randomize_resp(ids[$urandom_range(0, 3)]);
      run_txn(1'b0, to);
      bad = frames_bad();
      checks++; if (to || bad !== 0) begin errors++; $display("FAIL rand%0d_frames mismatches %0d timeout %0d", it, bad, to); end
      checks++; if (keys !== m_keys) begin errors++; $display("FAIL rand%0d_keys got %h want %h", it, keys, m_keys); end
      checks++; if (sticks !== m_sticks) begin errors++; $display("FAIL rand%0d_sticks got %h want %h", it, sticks, m_sticks); end
      checks++; if (debug1 !== m_dbg1) begin errors++; $display("FAIL rand%0d_debug1 got %h want %h", it, debug1, m_dbg1); end
      checks++; if (debug2 !== m_dbg2) begin errors++; $display("FAIL rand%0d_debug2 got %h want %h", it, debug2, m_dbg2); end
    end
  endtask

  task automatic test_back_to_back();
    bit to;
    int bad;
    analog = m_mode;
    randomize_resp(8'h79);
    run_txn(1'b1, to);
    bad = frames_bad();
    checks++; if (to || bad !== 0) begin errors++; $display("FAIL busy_frames mismatches %0d timeout %0d want 0 0", bad, to); end
    checks++; if (ds2_att !== 1'b1) begin errors++; $display("FAIL busy_att_idle got %b want 1", ds2_att); end
    checks++; if (debug2 !== m_dbg2) begin errors++; $display("FAIL busy_debug2 got %h want %h", debug2, m_dbg2); end
    checks++; if (sticks !== m_sticks) begin errors++; $display("FAIL busy_sticks got %h want %h", sticks, m_sticks); end
  endtask

  task automatic test_no_pad();
    bit to;
    int bad;
    pad_present = 1'b0;
    analog = m_mode;
    for (int it = 0; it < 2; it++) begin
      run_txn(1'b0, to);
      bad = frames_bad();
      checks++; if (to || bad !== 0) begin errors++; $display("FAIL nopad%0d_frames mismatches %0d timeout %0d", it, bad, to); end
      checks++; if (debug1 !== 8'hFF) begin errors++; $display("FAIL nopad%0d_debug1 got %h want ff", it, debug1); end
      checks++; if (keys !== 16'h0000) begin errors++; $display("FAIL nopad%0d_keys got %h want 0000", it, keys); end
      checks++; if (sticks !== m_sticks) begin errors++; $display("FAIL nopad%0d_sticks got %h want %h", it, sticks, m_sticks); end
      checks++; if (debug2 !== m_dbg2) begin errors++; $display("FAIL nopad%0d_debug2 got %h want %h", it, debug2, m_dbg2); end
    end
    pad_present = 1'b1;
  endtask

  task automatic test_timing();
    checks++; if (lo_min != CLK_HALF*T || lo_max != CLK_HALF*T) begin
      errors++; $display("FAIL clk_half min %0t max %0t want %0d", lo_min, lo_max, CLK_HALF*T); end
    checks++; if (cmd_viol !== 0) begin errors++; $display("FAIL cmd_stable violations %0d want 0", cmd_viol); end
    checks++; if (clk_outside !== 0) begin errors++; $display("FAIL clk_att_high edges %0d want 0", clk_outside); end
    checks++; if (partial !== 0) begin errors++; $display("FAIL partial_bytes frames %0d want 0", partial); end
  endtask

  task automatic test_reset_mid();
    bit to;
    int bad;
    analog = 1'b1;
    randomize_resp(8'h73);
    run_txn(1'b0, to);
    void'(frames_bad());
    // Now in analog mode: this vsync starts a POLL that gets cut short.
    pulse_vsync();
    for (int c = 0; c < 200 && ds2_att !== 1'b0; c++) @(negedge clk);
    repeat (ATT_SETUP + 2) @(negedge clk);
    mon_en = 1'b0;
    checks++; if (ds2_att !== 1'b0 || ds2_clk !== 1'b0) begin
      errors++; $display("FAIL rmid_precond att %b clk %b want 0 0", ds2_att, ds2_clk); end
    rst = 1'b0;
    #1;
    checks++; if (ds2_att !== 1'b1) begin errors++; $display("FAIL rmid_att got %b want 1", ds2_att); end
    checks++; if (ds2_clk !== 1'b1) begin errors++; $display("FAIL rmid_clk got %b want 1", ds2_clk); end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    m_mode = 1'b0; m_keys = 16'h0000; m_sticks = 32'h80808080; m_dbg1 = 8'h00; m_dbg2 = 8'h00;
    len_q.delete(); got_q.delete();
    repeat (3) @(negedge clk);
    mon_en = 1'b1;
    run_txn(1'b0, to);
    bad = frames_bad();
    checks++; if (to || bad !== 0) begin errors++; $display("FAIL rmid_reconfig mismatches %0d timeout %0d want 0 0", bad, to); end
    checks++; if (debug2 !== 8'h03) begin errors++; $display("FAIL rmid_debug2 got %h want 03", debug2); end
    checks++; if (keys !== 16'h0000) begin errors++; $display("FAIL rmid_keys got %h want 0000", keys); end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    for (int i = 0; i < 9; i++) resp[i] = 8'hFF;
    test_reset();
    test_digital_poll();
    test_analog_switch();
    test_return_digital();
    test_random();
    test_back_to_back();
    test_no_pad();
    test_timing();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
